// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and access sizes.
package lsu_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE       = 2'd0,
      LSU_REQUESTING = 2'd1,
      LSU_WAITING    = 2'd2,
      LSU_DONE       = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

endpackage : lsu_pkg

// File: rtl/lsu_align.sv
// Combinational lane logic: misalign detection, byte enables, store lane shift
// and load extract/extend for a 32-bit word with 4 byte lanes.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] resp_data_i,
   output logic        misalign_o,
   output logic [3:0]  we_o,
   output logic [31:0] store_lane_o,
   output logic [31:0] load_data_o
);

   logic [4:0]  shamt_s;
   logic [31:0] raw_s;

   assign shamt_s = {addr_lo_i, 3'b000};
   assign raw_s   = resp_data_i >> shamt_s;

   // Size-dependent enables, store placement and load extension
   always_comb begin
      misalign_o   = 1'b0;
      we_o         = 4'b0000;
      store_lane_o = 32'h0000_0000;
      load_data_o  = 32'h0000_0000;
      case (size_i)
         MEM_B: begin
            we_o         = 4'b0001 << addr_lo_i;
            store_lane_o = {24'h00_0000, store_data_i[7:0]} << shamt_s;
            load_data_o  = unsigned_i ? {24'h00_0000, raw_s[7:0]}
                                      : {{24{raw_s[7]}}, raw_s[7:0]};
         end
         MEM_H: begin
            misalign_o   = addr_lo_i[0];
            we_o         = 4'b0011 << addr_lo_i;
            store_lane_o = {16'h0000, store_data_i[15:0]} << shamt_s;
            load_data_o  = unsigned_i ? {16'h0000, raw_s[15:0]}
                                      : {{16{raw_s[15]}}, raw_s[15:0]};
         end
         MEM_W: begin
            misalign_o   = (addr_lo_i != 2'b00);
            we_o         = 4'b1111;
            store_lane_o = store_data_i;
            load_data_o  = raw_s;
         end
         default: begin
            misalign_o = 1'b1;
         end
      endcase
   end

endmodule : lsu_align

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one request on the memory controller's
// valid/ready port, aligns the response and holds the result until retire.
module lsu
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BYTES      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mem_read_en,
   input  logic                  mem_write_en,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic                  retire,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [BYTES-1:0]      req_we,
   output logic [ADDR_WIDTH-1:0] req_addr,
   output logic [DATA_WIDTH-1:0] req_data,
   input  logic                  req_resp_valid,
   input  logic [DATA_WIDTH-1:0] req_resp_data,
   output logic [1:0]            lsu_state,
   output logic [DATA_WIDTH-1:0] lsu_out,
   output logic                  lsu_err
);

   lsu_state_t            state_q, state_d;
   logic                  req_valid_q, req_valid_d;
   logic [BYTES-1:0]      req_we_q, req_we_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
   logic [DATA_WIDTH-1:0] lsu_out_q, lsu_out_d;
   logic                  lsu_err_q, lsu_err_d;
   logic                  is_load_q, is_load_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;

   logic                  in_idle_s, op_s, illegal_s, misalign_s, resp_hit_s;
   logic [1:0]            al_size_s, al_addr_s;
   logic                  al_uns_s;
   logic [3:0]            al_we_s;
   logic [31:0]           al_st_s, al_ld_s;

   // In IDLE the aligner sees the incoming op; afterwards the latched one
   assign in_idle_s  = (state_q == LSU_IDLE);
   assign al_size_s  = in_idle_s ? mem_size     : size_q;
   assign al_addr_s  = in_idle_s ? addr[1:0]    : req_addr_q[1:0];
   assign al_uns_s   = in_idle_s ? mem_unsigned : uns_q;
   assign op_s       = start && (mem_read_en || mem_write_en);
   assign illegal_s  = misalign_s || (mem_read_en && mem_write_en);
   assign resp_hit_s = req_resp_valid &&
                       (((state_q == LSU_REQUESTING) && req_ready) || (state_q == LSU_WAITING));

   lsu_align u_align (
      .size_i       (al_size_s),
      .addr_lo_i    (al_addr_s),
      .unsigned_i   (al_uns_s),
      .store_data_i (store_data),
      .resp_data_i  (req_resp_data),
      .misalign_o   (misalign_s),
      .we_o         (al_we_s),
      .store_lane_o (al_st_s),
      .load_data_o  (al_ld_s)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LSU_IDLE;
         req_valid_q <= 1'b0;
         req_we_q    <= {BYTES{1'b0}};
         req_addr_q  <= {ADDR_WIDTH{1'b0}};
         req_data_q  <= {DATA_WIDTH{1'b0}};
         lsu_out_q   <= {DATA_WIDTH{1'b0}};
         lsu_err_q   <= 1'b0;
         is_load_q   <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
         lsu_out_q   <= lsu_out_d;
         lsu_err_q   <= lsu_err_d;
         is_load_q   <= is_load_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: begin
            if (op_s) begin
               state_d = illegal_s ? LSU_DONE : LSU_REQUESTING;
            end else begin
               state_d = LSU_IDLE;
            end
         end
         LSU_REQUESTING: begin
            if (req_ready) begin
               state_d = req_resp_valid ? LSU_DONE : LSU_WAITING;
            end else begin
               state_d = LSU_REQUESTING;
            end
         end
         LSU_WAITING: begin
            if (req_resp_valid) begin
               state_d = LSU_DONE;
            end else begin
               state_d = LSU_WAITING;
            end
         end
         LSU_DONE: begin
            if (retire) begin
               state_d = LSU_IDLE;
            end else begin
               state_d = LSU_DONE;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   // Next values of the registered request/result outputs
   always_comb begin
      req_valid_d = req_valid_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_data_d  = req_data_q;
      lsu_out_d   = lsu_out_q;
      lsu_err_d   = lsu_err_q;
      is_load_d   = is_load_q;
      size_d      = size_q;
      uns_d       = uns_q;
      if (in_idle_s && op_s) begin
         lsu_err_d = illegal_s;
         if (!illegal_s) begin
            req_valid_d = 1'b1;
            req_addr_d  = addr;
            req_we_d    = mem_write_en ? al_we_s : {BYTES{1'b0}};
            req_data_d  = mem_write_en ? al_st_s : {DATA_WIDTH{1'b0}};
            is_load_d   = mem_read_en;
            size_d      = mem_size;
            uns_d       = mem_unsigned;
         end else begin
            req_valid_d = 1'b0;
         end
      end else if ((state_q == LSU_REQUESTING) && req_ready) begin
         req_valid_d = 1'b0;
      end else begin
         req_valid_d = req_valid_q;
      end
      if (resp_hit_s && is_load_q) begin
         lsu_out_d = al_ld_s;
      end else begin
         lsu_out_d = lsu_out_q;
      end
   end

   assign lsu_state = state_q;
   assign req_valid = req_valid_q;
   assign req_we    = req_we_q;
   assign req_addr  = req_addr_q;
   assign req_data  = req_data_q;
   assign lsu_out   = lsu_out_q;
   assign lsu_err   = lsu_err_q;

endmodule : lsu

// File: tb/tb_lsu.sv
// Directed bench for lsu: each task drives one scenario and checks inline
// against hand-computed values.
module tb_lsu;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        retire;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_we;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_resp_valid;
   logic [31:0] req_resp_data;
   logic [1:0]  lsu_state;
   logic [31:0] lsu_out;
   logic        lsu_err;

   int n_checks;
   int n_fail;

   lsu dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_size       (mem_size),
      .mem_unsigned   (mem_unsigned),
      .addr           (addr),
      .store_data     (store_data),
      .retire         (retire),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_resp_valid (req_resp_valid),
      .req_resp_data  (req_resp_data),
      .lsu_state      (lsu_state),
      .lsu_out        (lsu_out),
      .lsu_err        (lsu_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] sd);
      start = 1'b1; mem_read_en = rd; mem_write_en = wr; mem_size = sz;
      mem_unsigned = uns; addr = a; store_data = sd;
      step();
      start = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
   endtask

   // Grant immediately, return the response one cycle later.
   task automatic grant_and_respond(input logic [31:0] resp);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      req_resp_valid = 1'b1; req_resp_data = resp;
      step();
      req_resp_valid = 1'b0;
   endtask

   task automatic do_retire();
      retire = 1'b1;
      step();
      retire = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      n_checks++;
      if ({lsu_state, req_valid, req_we, lsu_err} !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctrl: got %h expected 00", {lsu_state, req_valid, req_we, lsu_err});
      end
      n_checks++;
      if ({req_addr, req_data, lsu_out} !== 96'h0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", {req_addr, req_data, lsu_out});
      end
   endtask

   task automatic test_word_load();
      int vcount;
      vcount = 0;
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
      n_checks++;
      if (req_we !== 4'b0000 || req_addr !== 32'h10) begin
         n_fail++; $display("FAIL wl_req: got we=%b addr=%h expected 0000 00000010", req_we, req_addr);
      end
      for (int i = 0; i < 6; i++) begin
         if (req_valid === 1'b1) vcount++;
         req_ready = (i == 2);
         step();
      end
      req_ready = 1'b0;
      n_checks++;
      if (vcount !== 3) begin
         n_fail++; $display("FAIL wl_valid_cycles: got %0d expected 3", vcount);
      end
      n_checks++;
      if (lsu_state !== 2'd2) begin
         n_fail++; $display("FAIL wl_waiting: got %0d expected 2", lsu_state);
      end
      req_resp_valid = 1'b1; req_resp_data = 32'hDEAD_BEEF;
      step();
      req_resp_valid = 1'b0;
      n_checks++;
      if (lsu_state !== 2'd3 || lsu_out !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wl_done: got st=%0d out=%h expected 3 deadbeef", lsu_state, lsu_out);
      end
      step();
      n_checks++;
      if (lsu_state !== 2'd3) begin
         n_fail++; $display("FAIL wl_hold: got %0d expected 3", lsu_state);
      end
      do_retire();
      n_checks++;
      if (lsu_state !== 2'd0) begin
         n_fail++; $display("FAIL wl_retire: got %0d expected 0", lsu_state);
      end
   endtask

   task automatic test_byte_load();
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
      grant_and_respond(32'h80FF_FF7F);
      n_checks++;
      if (lsu_out !== 32'hFFFF_FF80) begin
         n_fail++; $display("FAIL bl_signed: got %h expected ffffff80", lsu_out);
      end
      do_retire();
      issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
      grant_and_respond(32'h80FF_FF7F);
      n_checks++;
      if (lsu_out !== 32'h0000_0080) begin
         n_fail++; $display("FAIL bl_unsigned: got %h expected 00000080", lsu_out);
      end
      do_retire();
   endtask

   task automatic test_half_store();
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD);
      n_checks++;
      if (req_valid !== 1'b1 || req_we !== 4'b1100 || req_data !== 32'hABCD_0000) begin
         n_fail++; $display("FAIL hs_req: got v=%b we=%b data=%h expected 1 1100 abcd0000",
                            req_valid, req_we, req_data);
      end
      grant_and_respond(32'h5555_5555);
      n_checks++;
      if (lsu_state !== 2'd3 || lsu_out !== 32'h0000_0080) begin
         n_fail++; $display("FAIL hs_out: got st=%0d out=%h expected 3 00000080", lsu_state, lsu_out);
      end
      do_retire();
   endtask

   task automatic test_misalign();
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0);
      n_checks++;
      if (lsu_state !== 2'd3 || lsu_err !== 1'b1 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL ma_err: got st=%0d err=%b v=%b expected 3 1 0", lsu_state, lsu_err, req_valid);
      end
      do_retire();
      issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0);
      n_checks++;
      if (lsu_err !== 1'b0 || req_valid !== 1'b1) begin
         n_fail++; $display("FAIL ma_clear: got err=%b v=%b expected 0 1", lsu_err, req_valid);
      end
      grant_and_respond(32'h0000_AB00);
      n_checks++;
      if (lsu_out !== 32'h0000_00AB) begin
         n_fail++; $display("FAIL ma_next_load: got %h expected 000000ab", lsu_out);
      end
      do_retire();
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
      req_ready = 1'b1; req_resp_valid = 1'b1; req_resp_data = 32'h0000_0042;
      step();
      req_ready = 1'b0; req_resp_valid = 1'b0;
      n_checks++;
      if (lsu_state !== 2'd3 || lsu_out !== 32'h42 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL bb_done: got st=%0d out=%h v=%b expected 3 42 0", lsu_state, lsu_out, req_valid);
      end
      req_resp_valid = 1'b1; req_resp_data = 32'h0000_0099;
      step();
      req_resp_valid = 1'b0;
      n_checks++;
      if (lsu_out !== 32'h42) begin
         n_fail++; $display("FAIL bb_late_resp: got %h expected 42", lsu_out);
      end
      start = 1'b1; mem_read_en = 1'b1; mem_size = 2'b10; addr = 32'h0000_0080; retire = 1'b1;
      step();
      retire = 1'b0;
      start = 1'b0; mem_read_en = 1'b0;
      step();
      n_checks++;
      if (lsu_state !== 2'd0 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL bb_start_on_retire: got st=%0d v=%b expected 0 0", lsu_state, req_valid);
      end
   endtask

   task automatic test_reset_midop();
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0060, 32'h0);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (lsu_state !== 2'd0 || req_valid !== 1'b0 || lsu_out !== 32'h0) begin
         n_fail++; $display("FAIL rm_reset: got st=%0d v=%b out=%h expected 0 0 0", lsu_state, req_valid, lsu_out);
      end
      req_resp_valid = 1'b1; req_resp_data = 32'h1111_2222;
      step();
      req_resp_valid = 1'b0;
      n_checks++;
      if (lsu_state !== 2'd0 || lsu_out !== 32'h0) begin
         n_fail++; $display("FAIL rm_late_resp: got st=%0d out=%h expected 0 0", lsu_state, lsu_out);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1; start = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
      mem_size = 2'b00; mem_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0;
      retire = 1'b0; req_ready = 1'b0; req_resp_valid = 1'b0; req_resp_data = 32'h0;
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_misalign();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lsu
